// File: rtl/pwm_capture.sv
// Receive-side decoder for the LED matrix drive stream: rebuilds per-plane latch
// contents from the synchronized PWM drive pins and exposes them for CPU readback.
module pwm_capture #(
    parameter int N_LATCH = 12,
    parameter int N_PLANE = 5
) (
    input  logic               cpu_clk,
    input  logic               reset,
    input  logic               lsr_clr,
    input  logic               lsr_d,
    input  logic               lsr_c,
    input  logic [7:0]         latch_data,
    input  logic               psr_c,
    input  logic               psr_d,
    input  logic               col_enable,
    input  logic [6:0]         rd_addr,
    output logic [7:0]         rd_data,
    output logic [N_PLANE-1:0] plane_valid,
    output logic [2:0]         plane_idx,
    output logic               plane_ok,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         err_cnt
);

    localparam int NS   = 14;
    localparam int B_CLR = 13;
    localparam int B_LD  = 12;
    localparam int B_LC  = 11;
    localparam int B_PC  = 10;
    localparam int B_PD  = 9;
    localparam int B_CE  = 8;
    // Idle pin levels: lsr_clr and col_enable high, everything else low.
    localparam logic [NS-1:0] IDLE = 14'h2100;

    function automatic logic multi_hot(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

    logic [NS-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    prev_q, prev_d;
    logic          ev_lsr_q, ev_lsr_d, ev_psr_q, ev_psr_d;
    logic          clr_n_q, clr_n_d, ld_q, ld_d, pd_q, pd_d, ce_q, ce_d;
    logic [7:0]    data_q, data_d;

    logic [N_LATCH-1:0] sel_q, sel_d;
    logic [7:0]         lat_q [N_LATCH];
    logic [7:0]         lat_d [N_LATCH];
    logic [N_PLANE-1:0] pl_q, pl_d;
    logic [7:0]         snap_q [N_PLANE][N_LATCH];
    logic [7:0]         snap_d [N_PLANE][N_LATCH];
    logic [N_PLANE-1:0] pv_q, pv_d;
    logic [15:0]        frame_q, frame_d;
    logic [7:0]         err_q, err_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic [1:0]         err_inc;
    logic [8:0]         err_sum;
    logic               pl_one_hot;
    logic [2:0]         pl_idx;

    // Synchronizer, edge detect, then one event stage so data and its clock stay aligned.
    always_comb begin
        s1_d     = {lsr_clr, lsr_d, lsr_c, psr_c, psr_d, col_enable, latch_data};
        s2_d     = s1_q;
        prev_d   = {s2_q[B_LC], s2_q[B_PC]};
        ev_lsr_d = s2_q[B_LC] & ~prev_q[1];
        ev_psr_d = s2_q[B_PC] & ~prev_q[0];
        clr_n_d  = s2_q[B_CLR];
        ld_d     = s2_q[B_LD];
        pd_d     = s2_q[B_PD];
        ce_d     = s2_q[B_CE];
        data_d   = s2_q[7:0];
    end

    always_comb begin
        pl_one_hot = (pl_q != '0) && !multi_hot(16'(pl_q));
        pl_idx     = 3'd0;
        for (int p = 0; p < N_PLANE; p++) begin
            if (pl_q[p]) pl_idx = 3'(p);
        end
        if (!pl_one_hot) pl_idx = 3'd0;
    end

    always_comb begin
        sel_d   = sel_q;
        lat_d   = lat_q;
        pl_d    = pl_q;
        snap_d  = snap_q;
        pv_d    = pv_q;
        frame_d = frame_q;
        err_inc = 2'd0;

        if (!clr_n_q) begin
            sel_d = '0;
        end else if (ev_lsr_q) begin
            sel_d = (sel_q << 1) | N_LATCH'(ld_q);
            for (int i = 0; i < N_LATCH; i++) begin
                if (sel_d[i]) lat_d[i] = data_q;
            end
            if (multi_hot(16'(sel_d))) err_inc = err_inc + 2'd1;
        end

        // Snapshot reads lat_q, so a same-cycle latch load is not captured.
        if (ev_psr_q) begin
            pl_d = (pl_q << 1) | N_PLANE'(pd_q);
            if (pd_q) frame_d = frame_q + 16'd1;
            if (multi_hot(16'(pl_d))) err_inc = err_inc + 2'd1;
            for (int p = 0; p < N_PLANE; p++) begin
                if (pl_one_hot && pl_q[p]) begin
                    snap_d[p] = lat_q;
                    pv_d[p]   = ~ce_q;
                end
            end
        end

        err_sum = {1'b0, err_q} + 9'(err_inc);
        err_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    // Out-of-range addresses match no entry and read back as zero.
    always_comb begin
        rd_data_d = 8'h00;
        for (int p = 0; p < N_PLANE; p++) begin
            for (int l = 0; l < N_LATCH; l++) begin
                if (rd_addr[6:4] == 3'(p) && rd_addr[3:0] == 4'(l))
                    rd_data_d = snap_q[p][l];
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            s1_q      <= IDLE;
            s2_q      <= IDLE;
            prev_q    <= 2'b00;
            ev_lsr_q  <= 1'b0;
            ev_psr_q  <= 1'b0;
            clr_n_q   <= 1'b1;
            ld_q      <= 1'b0;
            pd_q      <= 1'b0;
            ce_q      <= 1'b1;
            data_q    <= 8'h00;
            sel_q     <= '0;
            pl_q      <= '0;
            pv_q      <= '0;
            frame_q   <= 16'd0;
            err_q     <= 8'd0;
            rd_data_q <= 8'h00;
            for (int i = 0; i < N_LATCH; i++) lat_q[i] <= 8'h00;
            for (int p = 0; p < N_PLANE; p++) begin
                for (int l = 0; l < N_LATCH; l++) snap_q[p][l] <= 8'h00;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            ev_lsr_q  <= ev_lsr_d;
            ev_psr_q  <= ev_psr_d;
            clr_n_q   <= clr_n_d;
            ld_q      <= ld_d;
            pd_q      <= pd_d;
            ce_q      <= ce_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            pl_q      <= pl_d;
            pv_q      <= pv_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            lat_q     <= lat_d;
            snap_q    <= snap_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign plane_valid = pv_q;
    assign plane_idx   = pl_idx;
    assign plane_ok    = pl_one_hot;
    assign frame_cnt   = frame_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected values, a monitor
// compares them when the registered readback/status response appears.
module tb_pwm_capture;

    localparam int K_RD = 0, K_PV = 1, K_IDX = 2, K_OK = 3, K_FR = 4, K_ERR = 5;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } item_t;

    logic       clk = 1'b0;
    logic       reset, lsr_clr, lsr_d, lsr_c, psr_c, psr_d, col_enable;
    logic [7:0] latch_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] plane_valid;
    logic [2:0] plane_idx;
    logic       plane_ok;
    logic [15:0] frame_cnt;
    logic [7:0] err_cnt;

    item_t exp_q[$];
    bit    req, req_q;
    int    errors = 0;
    int    checks = 0;

    pwm_capture #(.N_LATCH(12), .N_PLANE(5)) dut (
        .cpu_clk(clk), .reset(reset), .lsr_clr(lsr_clr), .lsr_d(lsr_d), .lsr_c(lsr_c),
        .latch_data(latch_data), .psr_c(psr_c), .psr_d(psr_d), .col_enable(col_enable),
        .rd_addr(rd_addr), .rd_data(rd_data), .plane_valid(plane_valid),
        .plane_idx(plane_idx), .plane_ok(plane_ok), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_q <= req;

    // Monitor: one response per request, sampled on the falling edge.
    always @(negedge clk) begin
        if (req_q) begin
            item_t       it;
            logic [15:0] act;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: response with empty scoreboard, rd_data=%h", rd_data);
            end else begin
                it = exp_q.pop_front();
                case (it.kind)
                    K_RD:    act = {8'h00, rd_data};
                    K_PV:    act = {11'd0, plane_valid};
                    K_IDX:   act = {13'd0, plane_idx};
                    K_OK:    act = {15'd0, plane_ok};
                    K_FR:    act = frame_cnt;
                    default: act = {8'h00, err_cnt};
                endcase
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end else begin
                    $display("check %s: %h", it.name, act);
                end
            end
        end
    end

    function automatic logic [6:0] ad(input int p, input int l);
        return {3'(p), 4'(l)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [6:0] addr, input logic [15:0] exp,
                       input string name);
        item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        rd_addr = addr;
        exp_q.push_back(it);
        req = 1'b1;
        cyc(1);
        req = 1'b0;
        cyc(1);
    endtask

    task automatic st(input int kind, input logic [15:0] exp, input string name);
        chk(kind, 7'd0, exp, name);
    endtask

    task automatic idle_inputs();
        lsr_clr = 1'b1; lsr_d = 1'b0; lsr_c = 1'b0; latch_data = 8'h00;
        psr_c = 1'b0; psr_d = 1'b0; col_enable = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic lsr_pulse(input logic d, input logic [7:0] data, input int h);
        lsr_d = d; latch_data = data; cyc(h);
        lsr_c = 1'b1; cyc(h);
        lsr_c = 1'b0; cyc(h);
    endtask

    task automatic psr_pulse(input logic d, input int h);
        psr_d = d; cyc(h);
        psr_c = 1'b1; cyc(h);
        psr_c = 1'b0; cyc(h);
    endtask

    task automatic both_pulse(input logic ld, input logic [7:0] data, input logic pd);
        lsr_d = ld; latch_data = data; psr_d = pd; cyc(3);
        lsr_c = 1'b1; psr_c = 1'b1; cyc(3);
        lsr_c = 1'b0; psr_c = 1'b0; cyc(3);
    endtask

    initial begin
        rd_addr = 7'd0;
        do_reset();

        // Reset state
        chk(K_RD, ad(0, 0), 16'h00, "rst_rd");
        st(K_PV, 16'h0, "rst_pv");
        st(K_IDX, 16'h0, "rst_idx");
        st(K_OK, 16'h0, "rst_ok");
        st(K_FR, 16'h0, "rst_frame");
        st(K_ERR, 16'h0, "rst_err");
        psr_pulse(1'b0, 3);
        cyc(3);
        st(K_ERR, 16'h0, "psr0_err");
        st(K_OK, 16'h0, "psr0_ok");
        st(K_PV, 16'h0, "psr0_pv");

        // Latch shift, then snapshot into plane 0 with columns enabled
        for (int i = 0; i < 12; i++) lsr_pulse(i == 0, 8'(8'h10 + i), 3);
        psr_pulse(1'b1, 3);
        col_enable = 1'b0;
        psr_pulse(1'b0, 3);
        col_enable = 1'b1;
        cyc(3);
        for (int i = 0; i < 12; i++)
            chk(K_RD, ad(0, i), 16'(8'h10 + i), $sformatf("lat_rd%0d", i));
        st(K_PV, 16'h1, "lat_pv");
        st(K_IDX, 16'h1, "lat_idx");
        st(K_OK, 16'h1, "lat_ok");
        st(K_FR, 16'h1, "lat_frame");
        st(K_ERR, 16'h0, "lat_err");

        // Full frames
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 5; k++) begin
                psr_pulse(k == 0, 3);
                st(K_IDX, 16'(k), $sformatf("frm%0d_idx%0d", f, k));
                st(K_OK, 16'h1, $sformatf("frm%0d_ok%0d", f, k));
            end
        end
        st(K_FR, 16'd3, "frm_count");
        st(K_ERR, 16'h0, "frm_err");
        st(K_PV, 16'h0, "frm_pv");

        // Plane errors and saturation
        psr_pulse(1'b1, 3);
        psr_pulse(1'b1, 3);
        st(K_ERR, 16'd1, "perr_err1");
        st(K_OK, 16'h0, "perr_ok");
        st(K_IDX, 16'h0, "perr_idx");
        col_enable = 1'b0;
        psr_pulse(1'b0, 3);
        col_enable = 1'b1;
        st(K_PV, 16'h0, "perr_nosnap");
        st(K_ERR, 16'd2, "perr_err2");
        for (int i = 0; i < 250; i++) psr_pulse(1'b1, 2);
        cyc(4);
        st(K_ERR, 16'd252, "perr_252");
        for (int i = 0; i < 50; i++) psr_pulse(1'b1, 2);
        cyc(4);
        st(K_ERR, 16'd255, "perr_sat");
        st(K_FR, 16'd305, "perr_frame");

        // Clear mid-chain and out-of-range readback
        do_reset();
        lsr_pulse(1'b1, 8'h21, 3);
        lsr_pulse(1'b0, 8'h22, 3);
        lsr_clr = 1'b0; cyc(4);
        lsr_clr = 1'b1; cyc(4);
        lsr_pulse(1'b0, 8'h33, 3);
        lsr_pulse(1'b0, 8'h34, 3);
        psr_pulse(1'b1, 3);
        psr_pulse(1'b0, 3);
        chk(K_RD, ad(0, 0), 16'h21, "clr_rd0");
        chk(K_RD, ad(0, 1), 16'h22, "clr_rd1");
        chk(K_RD, ad(0, 2), 16'h00, "clr_rd2");
        chk(K_RD, ad(0, 3), 16'h00, "clr_rd3");
        chk(K_RD, ad(5, 0), 16'h00, "oor_plane");
        chk(K_RD, ad(0, 12), 16'h00, "oor_latch");
        st(K_ERR, 16'h0, "clr_err");

        // Simultaneous latch and plane edges
        lsr_pulse(1'b1, 8'h50, 3);
        lsr_pulse(1'b0, 8'h51, 3);
        lsr_pulse(1'b0, 8'h52, 3);
        lsr_pulse(1'b0, 8'h53, 3);
        lsr_clr = 1'b0; cyc(4);
        lsr_clr = 1'b1; cyc(4);
        lsr_pulse(1'b1, 8'h60, 3);
        lsr_pulse(1'b0, 8'h61, 3);
        lsr_pulse(1'b0, 8'h62, 3);
        col_enable = 1'b0;
        both_pulse(1'b0, 8'hAA, 1'b0);
        col_enable = 1'b1;
        psr_pulse(1'b0, 3);
        chk(K_RD, ad(1, 3), 16'h53, "sim_old3");
        chk(K_RD, ad(1, 2), 16'h62, "sim_old2");
        chk(K_RD, ad(2, 3), 16'hAA, "sim_new3");
        chk(K_RD, ad(2, 0), 16'h60, "sim_new0");
        st(K_PV, 16'h2, "sim_pv");
        st(K_IDX, 16'h3, "sim_idx");
        st(K_ERR, 16'h0, "sim_err");

        // Reset mid-frame, then a clean frame
        psr_d = 1'b1; cyc(3);
        psr_c = 1'b1; cyc(2);
        do_reset();
        chk(K_RD, ad(2, 3), 16'h00, "mrst_rd");
        st(K_PV, 16'h0, "mrst_pv");
        st(K_OK, 16'h0, "mrst_ok");
        st(K_FR, 16'h0, "mrst_frame");
        st(K_ERR, 16'h0, "mrst_err");
        for (int i = 0; i < 12; i++) lsr_pulse(i == 0, 8'(8'h80 + i), 3);
        psr_pulse(1'b1, 3);
        col_enable = 1'b0;
        psr_pulse(1'b0, 3);
        col_enable = 1'b1;
        chk(K_RD, ad(0, 0), 16'h80, "post_rd0");
        chk(K_RD, ad(0, 5), 16'h85, "post_rd5");
        chk(K_RD, ad(0, 11), 16'h8B, "post_rd11");
        st(K_PV, 16'h1, "post_pv");
        st(K_IDX, 16'h1, "post_idx");
        st(K_FR, 16'h1, "post_frame");
        st(K_ERR, 16'h0, "post_err");

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) cyc(1);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
